// File: rtl/dfmul_selfcheck_seq.sv
// dfmul_selfcheck_seq
//   Self-check sequencer for floating-point multiplier cores. It walks
//   NUM_VECTORS entries of three single-port vector ROMs (A, B, golden Z;
//   1-cycle read latency), launches the core once per entry over the
//   ap_start/ap_ready/ap_done handshake, and compares each result bitwise
//   against the golden value.
// Ports:
//   ap_clk, ap_rst            clock, asynchronous active-high reset
//   ap_start, stop_on_error   run request; stop mode latched on acceptance
//   ap_done/ap_ready, ap_idle run-finished pulse, idle indication
//   ap_return                 saturating mismatch count of the last run
//   first_fail_idx            first failing index (all-ones if none)
//   fail_seen, timeout        mismatch seen / run aborted on core timeout
//   vec_address0, vec_ce0     shared ROM address and read enable
//   a_q0, b_q0, z_q0          ROM read data
//   core_start/ready/done     core handshake
//   core_a, core_b            registered operands, core_return result
module dfmul_selfcheck_seq #(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned NUM_VECTORS    = 20,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  input  logic              stop_on_error,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [CNT_W-1:0]  ap_return,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic              fail_seen,
  output logic              timeout,
  output logic [ADDR_W-1:0] vec_address0,
  output logic              vec_ce0,
  input  logic [DATA_W-1:0] a_q0,
  input  logic [DATA_W-1:0] b_q0,
  input  logic [DATA_W-1:0] z_q0,
  output logic              core_start,
  input  logic              core_ready,
  input  logic              core_done,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  input  logic [DATA_W-1:0] core_return
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VECTORS - 1);
  localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_START, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_sat;
  logic [ADDR_W-1:0] ffi_q, ffi_d;
  logic              fail_q, fail_d;
  logic              to_q, to_d;
  logic              soe_q, soe_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, z_q, z_d, res_q, res_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              ce_q, ce_d, start_q, start_d, done_q, done_d;
  logic              mismatch;

  assign cnt_sat  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign mismatch = (res_q != z_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ffi_d   = ffi_q;
    fail_d  = fail_q;
    to_d    = to_q;
    soe_d   = soe_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    res_d   = res_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          state_d = S_FETCH;
          idx_d   = '0;
          cnt_d   = '0;
          fail_d  = 1'b0;
          to_d    = 1'b0;
          ffi_d   = '1;
          soe_d   = stop_on_error;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        a_d     = a_q0;
        b_d     = b_q0;
        z_d     = z_q0;
        tcnt_d  = '0;  // LATCH is the only way into START
        state_d = S_START;
      end
      S_START, S_WAIT: begin
        tcnt_d = tcnt_q + TW'(1);
        // Same test in START and WAIT: done may arrive with ready (or alone
        // in WAIT); the start level itself is dropped by leaving START.
        if (core_done && (core_ready || state_q == S_WAIT)) begin
          res_d   = core_return;
          state_d = S_CHECK;
        end else if (tcnt_q == TO_LAST) begin
          to_d    = 1'b1;
          cnt_d   = cnt_sat;
          if (!fail_q) ffi_d = idx_q;
          state_d = S_DONE;
        end else if (core_ready) begin
          state_d = S_WAIT;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          cnt_d  = cnt_sat;
          fail_d = 1'b1;
          if (!fail_q) ffi_d = idx_q;
        end
        if ((mismatch && soe_q) || idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Handshake outputs are registered copies of the next-state decode.
    ce_d    = (state_d == S_FETCH);
    start_d = (state_d == S_START);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ffi_q   <= '1;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
      soe_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      res_q   <= '0;
      tcnt_q  <= '0;
      ce_q    <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ffi_q   <= ffi_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
      soe_q   <= soe_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      res_q   <= res_d;
      tcnt_q  <= tcnt_d;
      ce_q    <= ce_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  assign ap_done        = done_q;
  assign ap_ready       = done_q;
  assign ap_idle        = (state_q == S_IDLE) && !ap_start;
  assign ap_return      = cnt_q;
  assign first_fail_idx = ffi_q;
  assign fail_seen      = fail_q;
  assign timeout        = to_q;
  assign vec_address0   = idx_q;
  assign vec_ce0        = ce_q;
  assign core_start     = start_q;
  assign core_a         = a_q;
  assign core_b         = b_q;

endmodule
